// File: rtl/truth_table_extractor.sv
// -----------------------------------------------------------------------------
// truth_table_extractor
//
// Sweeps every input combination of a single-output N_IN-input gate and
// assembles its truth-table code. The bit ordering follows the library hex
// naming, so a gate named 0xNN reads back as NN.
//
// For each combination, the block holds the vector on stim for SETTLE_CYCLES
// cycles and then samples resp. When the sweep completes, the block publishes
// the table and compares it against the expected code that was latched at
// start.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle sweep request, honoured only when idle
//   expected   expected truth-table code, latched on the accepted start
//   stim       vector driven to the DUT inputs (bit N_IN-1 = in1)
//   resp       DUT output, synchronous to clk
//   busy       high from the accepted start until done
//   done       one-cycle pulse when table_out/match are updated
//   table_out  captured truth table, held until the next done
//   match      table_out == latched expected, held until the next done
// -----------------------------------------------------------------------------
module truth_table_extractor #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,
    localparam int TW           = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TW-1:0]   expected,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   table_out,
    output logic            match
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE_CYCLES - 1);
    // vec is one bit wider than stim, so the terminal compare is unambiguous.
    localparam logic [N_IN:0]   VEC_LAST = (N_IN + 1)'(TW - 1);
    localparam logic [N_IN:0]   VEC_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN:0]     vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic [TW-1:0]     shift_q, shift_d;
    logic [N_IN-1:0]   stim_q, stim_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TW-1:0]     table_q, table_d;
    logic              match_q, match_d;

    assign stim      = stim_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign match     = match_q;

    // Next-state and output logic for the sweep controller.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        shift_d = shift_q;
        stim_d  = stim_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        match_d = match_q;

        case (state_q)
            IDLE: begin
                stim_d = '0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = SWEEP;
                    busy_d  = 1'b1;
                    vec_d   = '0;
                    cnt_d   = '0;
                    exp_d   = expected;
                    shift_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Samples shift in from the LSB, so combination 0 ends
                    // up at the MSB after TW samples.
                    shift_d = {shift_q[TW-2:0], resp};
                    cnt_d   = '0;
                    if (vec_q == VEC_LAST) begin
                        state_d = FINISH;
                        stim_d  = '0;
                    end else begin
                        vec_d  = vec_q + VEC_ONE;
                        stim_d = vec_d[N_IN-1:0];
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH: begin
                table_d = shift_q;
                match_d = (shift_q == exp_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                stim_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                stim_d  = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep and clears results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            shift_q <= '0;
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            shift_q <= shift_d;
            stim_q  <= stim_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            match_q <= match_d;
        end
    end

endmodule

// File: tb/tb_truth_table_extractor.sv
// -----------------------------------------------------------------------------
// Testbench for truth_table_extractor.
//
// dut_a (N_IN=3, SETTLE_CYCLES=4) is driven by a selectable response model:
//   mode 0 : 0xA3 gate
//   mode 1 : in3
//   mode 2 : in1
//   mode 3 : 0xA3 gate behind three register stages
// dut_b (N_IN=3, SETTLE_CYCLES=2) sees the same delayed 0xA3 model.
// dut_c (N_IN=2, SETTLE_CYCLES=1) sees a 2-input AND gate.
// -----------------------------------------------------------------------------
module tb_truth_table_extractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    localparam logic [7:0] GATE_A3 = 8'hA3;

    // dut_a
    logic       start_a = 1'b0;
    logic [7:0] expected_a = 8'h00;
    logic [2:0] stim_a;
    logic       resp_a;
    logic       busy_a, done_a, match_a;
    logic [7:0] table_a;
    int         mode = 0;

    // dut_b
    logic       start_b = 1'b0;
    logic [7:0] expected_b = 8'h00;
    logic [2:0] stim_b;
    logic       resp_b;
    logic       busy_b, done_b, match_b;
    logic [7:0] table_b;

    // dut_c
    logic       start_c = 1'b0;
    logic [3:0] expected_c = 4'h0;
    logic [1:0] stim_c;
    logic       resp_c;
    logic       busy_c, done_c, match_c;
    logic [3:0] table_c;

    // Three-stage delayed 0xA3 models
    logic la1 = 1'b0, la2 = 1'b0, la3 = 1'b0;
    logic lb1 = 1'b0, lb2 = 1'b0, lb3 = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expected(expected_a),
        .stim(stim_a), .resp(resp_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .match(match_a)
    );

    truth_table_extractor #(.N_IN(3), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expected(expected_b),
        .stim(stim_b), .resp(resp_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .match(match_b)
    );

    truth_table_extractor #(.N_IN(2), .SETTLE_CYCLES(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .expected(expected_c),
        .stim(stim_c), .resp(resp_c), .busy(busy_c), .done(done_c),
        .table_out(table_c), .match(match_c)
    );

    // Delay lines for the latency models
    always @(posedge clk) begin
        la1 <= GATE_A3[3'd7 - stim_a];
        la2 <= la1;
        la3 <= la2;
        lb1 <= GATE_A3[3'd7 - stim_b];
        lb2 <= lb1;
        lb3 <= lb2;
    end

    // Response selection for dut_a
    always_comb begin
        case (mode)
            0:       resp_a = GATE_A3[3'd7 - stim_a];
            1:       resp_a = stim_a[0];
            2:       resp_a = stim_a[2];
            default: resp_a = la3;
        endcase
    end

    assign resp_b = lb3;
    assign resp_c = stim_c[1] & stim_c[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    function automatic logic cur_busy(input int which);
        case (which)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic cur_done(input int which);
        case (which)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    // Starts a sweep on the selected instance. lat is the number of edges
    // after the accepting edge E0 until done is seen. busy_cnt is the number
    // of cycles busy was high. With repulse set, start is re-pulsed at cycles
    // 5 and 20, and expected is corrupted at cycle 5.
    task automatic run_sweep(input int which, input logic [7:0] exp_code,
                             input bit repulse, output int lat, output int busy_cnt);
        @(negedge clk);
        case (which)
            0:       begin start_a = 1'b1; expected_a = exp_code; end
            1:       begin start_b = 1'b1; expected_b = exp_code; end
            default: begin start_c = 1'b1; expected_c = exp_code[3:0]; end
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        lat = 0;
        busy_cnt = cur_busy(which) ? 1 : 0;
        while (!cur_done(which) && lat < 200) begin
            if (repulse) begin
                start_a = (lat == 5 || lat == 20);
                if (lat == 5) expected_a = ~exp_code;
            end
            @(posedge clk); #1;
            lat++;
            if (cur_busy(which)) busy_cnt++;
        end
        start_a = 1'b0;
        if (lat >= 200) check("sweep_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        int lat, bc, extra;

        // Reset state
        #23;
        check("rst_stim",  32'(stim_a),  32'd0);
        check("rst_busy",  32'(busy_a),  32'd0);
        check("rst_done",  32'(done_a),  32'd0);
        check("rst_table", 32'(table_a), 32'd0);
        check("rst_match", 32'(match_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA3 gate
        mode = 0;
        run_sweep(0, 8'hA3, 1'b0, lat, bc);
        check("a3_latency", 32'(lat), 32'd33);
        check("a3_busy_cycles", 32'(bc), 32'd33);
        check("a3_table", 32'(table_a), 32'hA3);
        check("a3_match", 32'(match_a), 32'd1);
        @(posedge clk); #1;
        check("a3_done_pulse", 32'(done_a), 32'd0);
        check("a3_table_hold", 32'(table_a), 32'hA3);

        // Ordering: in3 then in1
        mode = 1;
        run_sweep(0, 8'h55, 1'b0, lat, bc);
        check("in3_table", 32'(table_a), 32'h55);
        check("in3_match", 32'(match_a), 32'd1);
        mode = 2;
        run_sweep(0, 8'h00, 1'b0, lat, bc);
        check("in1_table", 32'(table_a), 32'h0F);
        check("in1_match", 32'(match_a), 32'd0);

        // Settle window: delayed model
        mode = 3;
        repeat (5) @(negedge clk);
        run_sweep(0, 8'hA3, 1'b0, lat, bc);
        check("lat3_s4_table", 32'(table_a), 32'hA3);
        check("lat3_s4_match", 32'(match_a), 32'd1);
        run_sweep(1, 8'hA3, 1'b0, lat, bc);
        check("lat3_s2_differs", 32'(table_b != 8'hA3), 32'd1);
        check("lat3_s2_match", 32'(match_b), 32'd0);

        // start re-pulsed mid-sweep; expected changed mid-sweep
        mode = 0;
        run_sweep(0, 8'hA3, 1'b1, lat, bc);
        check("repulse_latency", 32'(lat), 32'd33);
        check("repulse_table", 32'(table_a), 32'hA3);
        check("repulse_match", 32'(match_a), 32'd1);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done_a) extra++;
        end
        check("repulse_single_done", 32'(extra), 32'd0);

        // Reset during a sweep
        run_sweep(0, 8'hA3, 1'b0, lat, bc);
        check("pre_rst_table", 32'(table_a), 32'hA3);
        @(negedge clk); start_a = 1'b1; expected_a = 8'hA3;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_stim",  32'(stim_a),  32'd0);
        check("abort_busy",  32'(busy_a),  32'd0);
        check("abort_done",  32'(done_a),  32'd0);
        check("abort_table", 32'(table_a), 32'd0);
        check("abort_match", 32'(match_a), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_sweep(0, 8'hA3, 1'b0, lat, bc);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_table", 32'(table_a), 32'hA3);
        check("post_rst_match", 32'(match_a), 32'd1);

        // N_IN=2, SETTLE_CYCLES=1, AND gate
        run_sweep(2, 8'h01, 1'b0, lat, bc);
        check("and2_latency", 32'(lat), 32'd5);
        check("and2_table", 32'(table_c), 32'h1);
        check("and2_match", 32'(match_c), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
